external_bus_responder: RTL and testbench

//  Target-side end of the CPU external bus: decodes the 16-bit address the CPU

---
 rtl/external_bus_responder.sv | 85 ++++++++
 tb/tb_external_bus_responder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/external_bus_responder.sv
// external_bus_responder: CPU external-bus target with low RAM, vector bytes and RDY wait states.
// Optional macro VECTOR_WRITE_PROTECT_EN makes $FFFA..$FFFF read-only and pulses writeFault on writes.
module external_bus_responder #(
   parameter int          RAM_ADDR_BITS  = 9,
   parameter int          WAIT_STATES    = 1,
   parameter logic [15:0] NMI_VECTOR     = 16'h0000,
   parameter logic [15:0] RESET_VECTOR   = 16'h0200,
   parameter logic [15:0] IRQ_VECTOR     = 16'h0000,
   parameter logic [7:0]  OPEN_BUS_VALUE = 8'hFF
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic [7:0] addressBusLow,
   input  logic [7:0] addressBusHigh,
   input  logic [7:0] dataFromCpu,
   input  logic       readNotWrite,
   input  logic       accessValid,
   output logic [7:0] dataToCpu,
   output logic       rdy,
   output logic       unmappedAccess,
   output logic       writeFault
);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t state;
   logic [15:0] addr_q, addr;
   logic rnw_q, rnw;
   logic [7:0] wdata_q, wdata;
   logic [3:0] wait_cnt;
   logic [7:0] ram [2**RAM_ADDR_BITS];
   logic [5:0][7:0] vec;
   logic accept, complete, is_ram, is_vec, protect;
   logic [2:0] vec_idx;
   logic [RAM_ADDR_BITS-1:0] ram_idx;
`ifdef VECTOR_WRITE_PROTECT_EN
   assign protect = 1'b1;
`else
   assign protect = 1'b0;
`endif
   assign accept   = state == IDLE && accessValid;
   assign complete = (accept && WAIT_STATES == 0) || (state == WAIT && wait_cnt == 4'd0);
   // Once stalled, the CPU bus is ignored and the latched request is serviced.
   assign addr    = state == WAIT ? addr_q : {addressBusHigh, addressBusLow};
   assign rnw     = state == WAIT ? rnw_q : readNotWrite;
   assign wdata   = state == WAIT ? wdata_q : dataFromCpu;
   assign is_ram  = (addr >> RAM_ADDR_BITS) == 16'd0;
   assign is_vec  = addr >= 16'hFFFA;
   assign vec_idx = addr[2:0] - 3'd2;
   assign ram_idx = addr[RAM_ADDR_BITS-1:0];
   always_ff @(posedge clk)
      if (complete && !rnw && is_ram) ram[ram_idx] <= wdata;
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         state          <= IDLE;
         rdy            <= 1'b1;
         dataToCpu      <= 8'h00;
         unmappedAccess <= 1'b0;
         writeFault     <= 1'b0;
         vec            <= {IRQ_VECTOR, RESET_VECTOR, NMI_VECTOR};
         addr_q         <= 16'h0000;
         rnw_q          <= 1'b1;
         wdata_q        <= 8'h00;
         wait_cnt       <= 4'd0;
      end else begin
         unmappedAccess <= complete && !is_ram && !is_vec;
         writeFault     <= complete && !rnw && is_vec && protect;
         if (accept) begin
            addr_q  <= {addressBusHigh, addressBusLow};
            rnw_q   <= readNotWrite;
            wdata_q <= dataFromCpu;
         end
         if (accept && WAIT_STATES != 0) begin
            state    <= WAIT;
            rdy      <= 1'b0;
            wait_cnt <= 4'(WAIT_STATES - 1);
         end else if (state == WAIT) begin
            if (wait_cnt == 4'd0) begin
               state <= IDLE;
               rdy   <= 1'b1;
            end else wait_cnt <= wait_cnt - 4'd1;
         end
         if (complete && rnw)
            dataToCpu <= is_ram ? ram[ram_idx] : is_vec ? vec[vec_idx] : OPEN_BUS_VALUE;
         if (complete && !rnw && is_vec && !protect) vec[vec_idx] <= wdata;
      end
endmodule

// File: tb/tb_external_bus_responder.sv
// tb_external_bus_responder: scoreboard bench for external_bus_responder.
// dut1 uses WAIT_STATES=1, dut3 uses WAIT_STATES=3; both share the CPU bus inputs.
module tb_external_bus_responder;
   logic clk = 1'b0, nrst = 1'b0;
   logic [7:0] abl = 8'h00, abh = 8'h00, dout = 8'h00;
   logic rnw = 1'b1, av = 1'b0;
   logic [7:0] d1, d3;
   logic r1, r3, u1, u3, f1, f3;
   int passed = 0, total = 0;
`ifdef VECTOR_WRITE_PROTECT_EN
   localparam bit WP = 1'b1;
`else
   localparam bit WP = 1'b0;
`endif
   typedef struct {logic [7:0] data; logic unm; logic flt; int lows;} exp_t;
   exp_t sb[$];
   always #5 clk = ~clk;
   external_bus_responder dut1 (
      .clk(clk), .nrst(nrst), .addressBusLow(abl), .addressBusHigh(abh),
      .dataFromCpu(dout), .readNotWrite(rnw), .accessValid(av),
      .dataToCpu(d1), .rdy(r1), .unmappedAccess(u1), .writeFault(f1));
   external_bus_responder #(.WAIT_STATES(3)) dut3 (
      .clk(clk), .nrst(nrst), .addressBusLow(abl), .addressBusHigh(abh),
      .dataFromCpu(dout), .readNotWrite(rnw), .accessValid(av),
      .dataToCpu(d3), .rdy(r3), .unmappedAccess(u3), .writeFault(f3));
   task automatic pulse_reset();
      @(negedge clk) nrst = 1'b0;
      @(negedge clk) nrst = 1'b1;
   endtask
   // One bus transaction: expectation queued at drive time, checked when rdy returns.
   task automatic access(input string tag, input bit sel, input bit wr, input logic [15:0] a,
                         input logic [7:0] d, input logic [7:0] ed, input bit eu, input bit ef,
                         input bit hop, input logic [15:0] ha);
      exp_t e;
      int lows = 0;
      sb.push_back('{ed, eu, ef, sel ? 3 : 1});
      @(negedge clk);
      {abh, abl} = a;
      dout = d;
      rnw = !wr;
      av = 1'b1;
      @(negedge clk);
      av = 1'b0;
      if (hop) {abh, abl} = ha;
      while ((sel ? r3 : r1) === 1'b0 && lows < 40) begin
         lows++;
         @(negedge clk);
      end
      e = sb.pop_front();
      total++;
      if (lows !== e.lows) $display("FAIL %s rdy-low cycles got %0d exp %0d", tag, lows, e.lows);
      else passed++;
      total++;
      if ((sel ? d3 : d1) !== e.data) $display("FAIL %s data got %h exp %h", tag, sel ? d3 : d1, e.data);
      else passed++;
      total++;
      if ((sel ? u3 : u1) !== e.unm) $display("FAIL %s unmapped got %b exp %b", tag, sel ? u3 : u1, e.unm);
      else passed++;
      total++;
      if ((sel ? f3 : f1) !== e.flt) $display("FAIL %s writeFault got %b exp %b", tag, sel ? f3 : f1, e.flt);
      else passed++;
      @(negedge clk);
      total++;
      if ((sel ? u3 : u1) !== 1'b0 || (sel ? f3 : f1) !== 1'b0)
         $display("FAIL %s pulse width got unm=%b flt=%b exp 0/0", tag, sel ? u3 : u1, sel ? f3 : f1);
      else passed++;
   endtask
   task automatic test_reset();
      nrst = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (d1 !== 8'h00 || d3 !== 8'h00) $display("FAIL reset data got %h/%h exp 00", d1, d3); else passed++;
      total++;
      if (r1 !== 1'b1 || r3 !== 1'b1) $display("FAIL reset rdy got %b/%b exp 1", r1, r3); else passed++;
      total++;
      if (u1 !== 1'b0 || f1 !== 1'b0) $display("FAIL reset pulses got %b/%b exp 0", u1, f1); else passed++;
      @(negedge clk) nrst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (r1 !== 1'b1 || u1 !== 1'b0) $display("FAIL idle rdy/unm got %b/%b exp 1/0", r1, u1); else passed++;
   endtask
   task automatic test_vectors();
      access("read FFFC", 0, 0, 16'hFFFC, 8'h00, 8'h00, 0, 0, 0, 16'h0);
      access("read FFFD", 0, 0, 16'hFFFD, 8'h00, 8'h02, 0, 0, 0, 16'h0);
   endtask
   task automatic test_ram();
      access("write 0042", 0, 1, 16'h0042, 8'hA5, 8'h02, 0, 0, 0, 16'h0);
      access("read 0042", 0, 0, 16'h0042, 8'h00, 8'hA5, 0, 0, 0, 16'h0);
      access("write 01FF", 0, 1, 16'h01FF, 8'h3C, 8'hA5, 0, 0, 0, 16'h0);
      access("read 01FF", 0, 0, 16'h01FF, 8'h00, 8'h3C, 0, 0, 0, 16'h0);
   endtask
   task automatic test_back_to_back();
      exp_t e;
      @(negedge clk);
      {abh, abl} = 16'h0055;
      dout = 8'h5C;
      rnw = 1'b0;
      av = 1'b1;
      @(negedge clk);
      rnw = 1'b1;
      total++;
      if (r1 !== 1'b0) $display("FAIL b2b write stall got %b exp 0", r1); else passed++;
      sb.push_back('{8'h5C, 1'b0, 1'b0, 1});
      @(negedge clk);
      total++;
      if (r1 !== 1'b1) $display("FAIL b2b write done got %b exp 1", r1); else passed++;
      @(negedge clk);
      av = 1'b0;
      total++;
      if (r1 !== 1'b0) $display("FAIL b2b read accepted got rdy %b exp 0", r1); else passed++;
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (d1 !== e.data) $display("FAIL b2b read data got %h exp %h", d1, e.data); else passed++;
      total++;
      if (r1 !== 1'b1) $display("FAIL b2b read done got %b exp 1", r1); else passed++;
   endtask
   task automatic test_unmapped();
      access("read 8000", 0, 0, 16'h8000, 8'h00, 8'hFF, 1, 0, 0, 16'h0);
      access("write 8000", 0, 1, 16'h8000, 8'h12, 8'hFF, 1, 0, 0, 16'h0);
      access("reread 8000", 0, 0, 16'h8000, 8'h00, 8'hFF, 1, 0, 0, 16'h0);
      access("read 0200", 0, 0, 16'h0200, 8'h00, 8'hFF, 1, 0, 0, 16'h0);
      access("read 01FF again", 0, 0, 16'h01FF, 8'h00, 8'h3C, 0, 0, 0, 16'h0);
   endtask
   task automatic test_wait_states();
      pulse_reset();
      access("ws3 write 0010", 1, 1, 16'h0010, 8'h5A, 8'h00, 0, 0, 0, 16'h0);
      access("ws3 write 0020", 1, 1, 16'h0020, 8'hC3, 8'h00, 0, 0, 0, 16'h0);
      access("ws3 read hop", 1, 0, 16'h0010, 8'h00, 8'h5A, 0, 0, 1, 16'h0020);
   endtask
   task automatic test_reset_mid_wait();
      pulse_reset();
      access("write 0000=11", 0, 1, 16'h0000, 8'h11, 8'h00, 0, 0, 0, 16'h0);
      access("read 0000", 0, 0, 16'h0000, 8'h00, 8'h11, 0, 0, 0, 16'h0);
      @(negedge clk);
      {abh, abl} = 16'h0000;
      dout = 8'h22;
      rnw = 1'b0;
      av = 1'b1;
      @(negedge clk);
      av = 1'b0;
      total++;
      if (r1 !== 1'b0) $display("FAIL midwait stall got %b exp 0", r1); else passed++;
      #2 nrst = 1'b0;
      #1;
      total++;
      if (r1 !== 1'b1) $display("FAIL midwait reset rdy got %b exp 1", r1); else passed++;
      total++;
      if (d1 !== 8'h00) $display("FAIL midwait reset data got %h exp 00", d1); else passed++;
      @(negedge clk) nrst = 1'b1;
      rnw = 1'b1;
      access("read 0000 after reset", 0, 0, 16'h0000, 8'h00, 8'h11, 0, 0, 0, 16'h0);
   endtask
   task automatic test_vector_write();
      access("write FFFE", 0, 1, 16'hFFFE, 8'h77, 8'h11, 0, WP, 0, 16'h0);
      access("read FFFE", 0, 0, 16'hFFFE, 8'h00, WP ? 8'h00 : 8'h77, 0, 0, 0, 16'h0);
      access("read FFFD", 0, 0, 16'hFFFD, 8'h00, 8'h02, 0, 0, 0, 16'h0);
   endtask
   initial begin
      test_reset();
      test_vectors();
      test_ram();
      test_back_to_back();
      test_unmapped();
      test_wait_states();
      test_reset_mid_wait();
      test_vector_write();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog timeout after %0d/%0d checks", passed, total);
      $fatal(1);
   end
endmodule
